// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and sequencer state encoding
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between control stage and the sequenced ALU
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, aluControl, src_a, src_b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, aluControl, src_a, src_b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_shift_serial.sv
// rtl/alu_shift_serial.sv - bit-serial left shifter, one position per step
module alu_shift_serial #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   acc_o,
  output logic               finished_o
);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = data_i;
      cnt_d = shamt_i;
    end else if (step_i && (cnt_q != '0)) begin
      acc_d = {acc_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o      = acc_q;
  assign finished_o = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle add/xor/sub, bit-serial sll, done pulse
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] op_result, shift_acc;
  logic             op_illegal, accept, shift_step, shift_finished;

  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign shift_step = (state_q == ST_EXEC) && (code_q == ALU_SLL);

  // Shifter loads straight from the bus so its first EXEC cycle already holds src_a.
  alu_shift_serial #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .step_i     (shift_step),
    .data_i     (bus.src_a),
    .shamt_i    (bus.src_b[SHAMT_W-1:0]),
    .acc_o      (shift_acc),
    .finished_o (shift_finished)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_EXEC;
      ST_EXEC: if ((code_q != ALU_SLL) || shift_finished) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (code_q)
      ALU_ADD: op_result = a_q + b_q;
      ALU_XOR: op_result = a_q ^ b_q;
      ALU_SUB: op_result = a_q - b_q;
      ALU_SLL: op_result = shift_acc;
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    code_d    = code_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept) begin
      code_d    = bus.aluControl;
      a_d       = bus.src_a;
      b_d       = bus.src_b;
      illegal_d = 1'b0;
    end
    // Results commit only on the EXEC->DONE transition so they hold through IDLE.
    if ((state_q == ST_EXEC) && (state_d == ST_DONE)) begin
      result_d  = op_result;
      zero_d    = (op_result == '0);
      illegal_d = op_illegal;
    end
  end

  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.done    = (state_q == ST_DONE);
    bus.result  = result_q;
    bus.zero    = zero_q;
    bus.illegal = illegal_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized scoreboard bench for alu_seq
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
    exp_t e;
    int   sh;
    sh     = int'(b % 32);
    e.name = name;
    e.ill  = 1'b0;
    e.lat  = 1;
    e.t0   = 0;
    if (c == 4'd2)      e.res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    else if (c == 4'd3) e.res = a ^ b;
    else if (c == 4'd6) e.res = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
    else if (c == 4'd4) begin
      e.res = 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      e.lat = 1 + sh;
    end else begin
      e.res = 32'd0;
      e.ill = 1'b1;
    end
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_result"}, bus.result, e.res);
          chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.zero));
          chk({e.name, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
          chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
          chk({e.name, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    bus.start      = 1'b1;
    bus.aluControl = c;
    bus.src_a      = a;
    bus.src_b      = b;
    @(posedge clk);
    #1;
    e    = model(c, a, b, name);
    e.t0 = cyc;
    sb.push_back(e);
    bus.start      = 1'b0;
    bus.aluControl = 4'($urandom);
    bus.src_a      = $urandom;
    bus.src_b      = $urandom;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  logic [3:0] codes [4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0110};

  initial begin
    logic [3:0] c;
    bool_loop: begin end
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.aluControl = 4'd0;
    bus.src_a      = 32'd0;
    bus.src_b      = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    rst_n = 1'b1;

    issue(4'b0010, 32'd5, 32'd7, "add_5_7");
    issue(4'b0110, 32'h1234, 32'h1234, "bne_eq");
    issue(4'b0110, 32'd3, 32'd4, "bne_ne");
    issue(4'b0011, 32'hF0F0F0F0, 32'hFFFF0000, "xor");
    issue(4'b0010, 32'hFFFFFFFF, 32'd1, "add_wrap");
    issue(4'b0100, 32'd1, 32'd31, "sll_31");
    issue(4'b0100, 32'hA5, 32'h20, "sll_0");
    issue(4'b0111, 32'd9, 32'd9, "illegal_0111");
    drain("directed");

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 4);
      c = (k == 4) ? 4'($urandom_range(0, 15)) : codes[k];
      issue(c, $urandom, $urandom, "rand");
    end
    drain("random");

    issue(4'b0100, 32'd3, 32'd10, "sll_busy");
    bus.start      = 1'b1;
    bus.aluControl = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("busy_hold", 32'(bus.busy), 32'd1);
      if (bus.done === 1'b1) break;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(bus.busy), 32'd0);

    issue(4'b0100, 32'h55, 32'd20, "sll_abort");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_illegal", 32'(bus.illegal), 32'd0);
    repeat (25) @(negedge clk);
    issue(4'b0010, 32'd100, 32'd23, "add_after_abort");
    drain("final");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
